// File: rtl/mem_stage.sv
// Memory stage: holds one entry, waits for the data SRAM response of loads,
// extends load data and hands the entry to write-back.
module mem_stage #(
    parameter int ES_MS_W = 154,
    parameter int MS_WS_W = 149
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               es_to_ms_valid,
    input  logic [ES_MS_W-1:0] es_to_ms_bus,
    output logic               ms_allowin,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic [MS_WS_W-1:0] ms_to_ws_bus,
    input  logic               data_sram_data_ok,
    input  logic [31:0]        data_sram_rdata,
    input  logic               ws_flush,
    output logic [38:0]        ms_fwd_bus
);

    logic               ms_valid_reg;
    logic               ms_valid_next;
    logic [ES_MS_W-1:0] payload_reg;
    logic [31:0]        buf_data_reg;
    logic               buf_valid_reg;
    logic               buf_valid_next;
    logic [1:0]         cancel_cnt_reg;
    logic [1:0]         cancel_cnt_next;

    logic        data_req_sent;
    logic [31:0] rt_value;
    logic [4:0]  cp0_addr;
    logic        mtc0_we;
    logic        res_from_cp0;
    logic        eret;
    logic        bd;
    logic [31:0] badvaddr;
    logic [4:0]  excode;
    logic        ex;
    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {data_req_sent, rt_value, cp0_addr, mtc0_we, res_from_cp0, eret, bd,
            badvaddr, excode, ex, ld_type, res_from_mem, gr_we, dest,
            alu_result, pc} = payload_reg;

    logic need_wait;
    logic data_ok_eff;
    logic ms_ready_go;
    logic handoff;
    logic awaiting;
    logic capture;
    logic cancel_inc;
    logic cancel_dec;

    // Responses owed to flushed entries are swallowed before any new one counts.
    assign need_wait   = data_req_sent && !ex;
    assign data_ok_eff = data_sram_data_ok && (cancel_cnt_reg == 2'd0);
    assign ms_ready_go = !need_wait || buf_valid_reg || data_ok_eff;

    assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign handoff        = ms_to_ws_valid && ws_allowin;

    assign awaiting   = ms_valid_reg && need_wait && !buf_valid_reg;
    assign capture    = awaiting && data_ok_eff && !handoff && !ws_flush;
    assign cancel_inc = ws_flush && awaiting && !data_ok_eff;
    assign cancel_dec = data_sram_data_ok && (cancel_cnt_reg != 2'd0);

    always_comb begin
        ms_valid_next = ms_valid_reg;
        if (ws_flush) begin
            ms_valid_next = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_next = es_to_ms_valid;
        end

        buf_valid_next = buf_valid_reg;
        if (handoff || ws_flush) begin
            buf_valid_next = 1'b0;
        end else if (capture) begin
            buf_valid_next = 1'b1;
        end

        cancel_cnt_next = cancel_cnt_reg;
        if (cancel_inc && !cancel_dec) begin
            if (cancel_cnt_reg != 2'd3) begin
                cancel_cnt_next = cancel_cnt_reg + 2'd1;
            end
        end else if (!cancel_inc && cancel_dec) begin
            cancel_cnt_next = cancel_cnt_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_reg   <= 1'b0;
            buf_valid_reg  <= 1'b0;
            cancel_cnt_reg <= 2'd0;
        end else begin
            ms_valid_reg   <= ms_valid_next;
            buf_valid_reg  <= buf_valid_next;
            cancel_cnt_reg <= cancel_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            payload_reg <= es_to_ms_bus;
        end
        if (capture) begin
            buf_data_reg <= data_sram_rdata;
        end
    end

    // Load data extraction: split the word into byte lanes, then pick per ld_type.
    logic [31:0] load_word;
    logic [7:0]  load_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic [31:0] final_result;

    assign load_word = buf_valid_reg ? buf_data_reg : data_sram_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign load_bytes[gi] = load_word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = load_bytes[alu_result[1:0]];
    assign sel_half = alu_result[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        case (ld_type)
            3'd1:    load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'd2:    load_ext = {24'd0, sel_byte};
            3'd3:    load_ext = {{16{sel_half[15]}}, sel_half};
            3'd4:    load_ext = {16'd0, sel_half};
            default: load_ext = load_word;
        endcase
    end

    assign final_result = res_from_mem ? load_ext : alu_result;

    assign ms_to_ws_bus = {rt_value, eret, bd, mtc0_we, cp0_addr, res_from_cp0,
                           badvaddr, ex, excode, gr_we && !ex, dest,
                           final_result, pc};

    assign ms_fwd_bus = {ms_valid_reg && res_from_mem && !ms_ready_go,
                         ms_valid_reg && gr_we && !ex,
                         dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction scoreboard checks every handoff,
// literal checks pin the specific scenarios.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic [153:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [148:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_flush;
    logic [38:0]  ms_fwd_bus;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_flush          (ws_flush),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [2:0]  lt;
        logic        rfm;
        logic        gwe;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        ex;
        logic [4:0]  exc;
    } entry_t;

    typedef struct packed {
        logic [148:0] bus;
        logic [38:0]  fwd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   handoffs = 0;
    entry_t cur;

    task automatic chk(input string name, input logic [148:0] got, input logic [148:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic entry_t mk(input logic req, input logic [2:0] lt, input logic rfm,
                                  input logic gwe, input logic [4:0] dst, input logic [31:0] alu,
                                  input logic ex, input logic [4:0] exc);
        entry_t e;
        e.req = req; e.lt = lt; e.rfm = rfm; e.gwe = gwe; e.dst = dst;
        e.alu = alu; e.pc = 32'hbfc0_0000 + {alu[15:0], 2'b00}; e.ex = ex; e.exc = exc;
        return e;
    endfunction

    function automatic logic [153:0] es_of(input entry_t e);
        logic [31:0] rt;
        logic [31:0] badv;
        rt   = e.pc ^ 32'h5a5a_a5a5;
        badv = e.alu + 32'h10;
        return {e.req, rt, e.dst, e.pc[2], e.pc[3], e.pc[4], e.pc[5], badv,
                e.exc, e.ex, e.lt, e.rfm, e.gwe, e.dst, e.alu, e.pc};
    endfunction

    // Load extension computed arithmetically from the address offset.
    function automatic logic [31:0] ext_model(input logic [2:0] lt, input logic [31:0] addr,
                                              input logic [31:0] data);
        int off;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(addr % 4);
        b = (data >> (8 * off)) & 32'hff;
        h = (data >> (16 * (off / 2))) & 32'hffff;
        case (lt)
            3'd1: return (b >= 32'd128) ? b + 32'hffff_ff00 : b;
            3'd2: return b;
            3'd3: return (h >= 32'd32768) ? h + 32'hffff_0000 : h;
            3'd4: return h;
            default: return data;
        endcase
    endfunction

    function automatic exp_t exp_of(input entry_t e, input logic [31:0] data);
        exp_t x;
        logic [31:0] fin;
        logic        we;
        fin = e.rfm ? ext_model(e.lt, e.alu, data) : e.alu;
        we  = e.gwe && !e.ex;
        x.bus = {e.pc ^ 32'h5a5a_a5a5, e.pc[4], e.pc[5], e.pc[2], e.dst, e.pc[3],
                 e.alu + 32'h10, e.ex, e.exc, we, e.dst, fin, e.pc};
        x.fwd = {1'b0, we, e.dst, fin};
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input entry_t e);
        cur = e;
        es_to_ms_bus = es_of(e);
        es_to_ms_valid = 1'b1;
    endtask

    task automatic expect_out(input logic [31:0] data);
        exp_q.push_back(exp_of(cur, data));
    endtask

    // Scoreboard: every accepted handoff must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            handoffs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_handoff", {148'd0, 1'b1}, 149'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("handoff pc=%h result=%h", ms_to_ws_bus[31:0], ms_to_ws_bus[63:32]);
                chk("ws_bus", ms_to_ws_bus, e.bus);
                chk("fwd_bus", {110'd0, ms_fwd_bus}, {110'd0, e.fwd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        entry_t e;
        int h0;
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_flush = 1'b0;
        step(); step();
        chk("reset_ms_to_ws_valid", {148'd0, ms_to_ws_valid}, 149'd0);
        chk("reset_fwd_flags", {147'd0, ms_fwd_bus[38:37]}, 149'd0);
        chk("reset_allowin", {148'd0, ms_allowin}, 149'd1);
        reset = 1'b0;

        // LW with data_ok in the first cycle
        offer(mk(1, 3'd0, 1, 1, 5'd3, 32'h1000, 0, 0)); step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hdead_beef; expect_out(32'hdead_beef);
        @(negedge clk);
        chk("lw_valid", {148'd0, ms_to_ws_valid}, 149'd1);
        chk("lw_result", {117'd0, ms_to_ws_bus[63:32]}, {117'd0, 32'hdead_beef});
        step(); data_sram_data_ok = 1'b0;

        // LB at offset 3, then LHU at offset 2
        offer(mk(1, 3'd1, 1, 1, 5'd4, 32'h2003, 0, 0)); step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("lb_blocked", {148'd0, ms_fwd_bus[38]}, 149'd1);
        chk("lb_not_valid", {148'd0, ms_to_ws_valid}, 149'd0);
        step();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8012_3456; expect_out(32'h8012_3456);
        @(negedge clk);
        chk("lb_result", {117'd0, ms_to_ws_bus[63:32]}, {117'd0, 32'hffff_ff80});
        step(); data_sram_data_ok = 1'b0;
        offer(mk(1, 3'd4, 1, 1, 5'd5, 32'h2002, 0, 0)); step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; expect_out(32'h8012_3456);
        @(negedge clk);
        chk("lhu_result", {117'd0, ms_to_ws_bus[63:32]}, {117'd0, 32'h0000_8012});
        step(); data_sram_data_ok = 1'b0;

        // LW response buffered while write-back stalls
        offer(mk(1, 3'd0, 1, 1, 5'd6, 32'h3000, 0, 0)); step();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hcafe_f00d; step();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_allowin", {148'd0, ms_allowin}, 149'd0);
            chk("stall_valid", {148'd0, ms_to_ws_valid}, 149'd1);
            step();
        end
        ws_allowin = 1'b1; expect_out(32'hcafe_f00d);
        @(negedge clk);
        chk("buffered_result", {117'd0, ms_to_ws_bus[63:32]}, {117'd0, 32'hcafe_f00d});
        step();

        // Flush with load outstanding: the next response belongs to the dead load
        offer(mk(1, 3'd0, 1, 1, 5'd7, 32'h4000, 0, 0)); step();
        es_to_ms_valid = 1'b0; step();
        ws_flush = 1'b1; step(); ws_flush = 1'b0;
        offer(mk(1, 3'd0, 1, 1, 5'd8, 32'h4004, 0, 0)); step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11;
        @(negedge clk);
        chk("cancel_discard", {148'd0, ms_to_ws_valid}, 149'd0);
        step();
        data_sram_rdata = 32'h22; expect_out(32'h22);
        @(negedge clk);
        chk("after_cancel_result", {117'd0, ms_to_ws_bus[63:32]}, {117'd0, 32'h22});
        step(); data_sram_data_ok = 1'b0;

        // Flush and new entry in the same cycle
        offer(mk(0, 3'd0, 0, 1, 5'd9, 32'h4100, 0, 0)); ws_flush = 1'b1; step();
        es_to_ms_valid = 1'b0; ws_flush = 1'b0;
        @(negedge clk);
        chk("flush_wins", {148'd0, ms_to_ws_valid}, 149'd0);
        step();

        // Exception entry passes straight through with gr_we squashed
        offer(mk(0, 3'd0, 0, 1, 5'd10, 32'h4200, 1, 5'd4)); step();
        es_to_ms_valid = 1'b0; expect_out(32'h0);
        @(negedge clk);
        chk("ex_valid", {148'd0, ms_to_ws_valid}, 149'd1);
        chk("ex_gr_we", {148'd0, ms_to_ws_bus[69]}, 149'd0);
        chk("ex_excode", {144'd0, ms_to_ws_bus[74:70]}, 149'd4);
        chk("ex_fwd_we", {148'd0, ms_fwd_bus[37]}, 149'd0);
        step();

        // Back-to-back ALU ops
        h0 = handoffs;
        for (int i = 0; i < 4; i++) begin
            e = mk(0, 3'd0, 0, 1, 5'(12 + i), 32'h5100 + 32'(i * 7), 0, 0);
            if (i > 0) expect_out(32'h0);
            offer(e);
            @(negedge clk);
            chk("b2b_allowin", {148'd0, ms_allowin}, 149'd1);
            step();
        end
        es_to_ms_valid = 1'b0; expect_out(32'h0); step();
        chk("b2b_count", 149'(handoffs - h0), 149'd4);

        // Reset during an outstanding load, then a stray response
        offer(mk(1, 3'd0, 1, 1, 5'd20, 32'h6000, 0, 0)); step();
        es_to_ms_valid = 1'b0; step();
        reset = 1'b1; step(); reset = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55; step();
        data_sram_data_ok = 1'b0;
        offer(mk(1, 3'd0, 1, 1, 5'd21, 32'h6004, 0, 0)); step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("stray_ignored", {148'd0, ms_to_ws_valid}, 149'd0);
        chk("post_reset_blocked", {148'd0, ms_fwd_bus[38]}, 149'd1);
        step();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h44; expect_out(32'h44);
        @(negedge clk);
        chk("post_reset_result", {117'd0, ms_to_ws_bus[63:32]}, {117'd0, 32'h44});
        step(); data_sram_data_ok = 1'b0;
        step(); step();

        chk("queue_empty", 149'(exp_q.size()), 149'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
